// File: rtl/msgPass_config_pkg.sv
// Shared widths, enums and constants for the message-passing buffer.
package msgPass_config_pkg;

    localparam int MSGPASS_BUFF_ADDR_WIDTH  = 7;
    localparam int MSGPASS_BUFF_RDATA_WIDTH = 10;
    localparam int INCREMENT_SRC_SEL_WIDTH  = 2;
    localparam int MSGPASS_RD_FIFO_DEPTH    = 2;

    typedef enum logic [1:0] {
        STEP_INC1   = 2'd0,
        STEP_STRIDE = 2'd1,
        STEP_HOLD   = 2'd2,
        STEP_RSVD   = 2'd3
    } step_sel_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/msgpass_rd_skid_fifo.sv
// Two-entry FIFO for {last,data} words; the head entry is a flop and
// drives the stream directly, so there is no combinational bypass.
module msgpass_rd_skid_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         pop;

    assign pop = (cnt_q != 2'd0) && rd_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case (cnt_q)
            2'd0: begin
                if (wr_en) begin
                    head_d = wr_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (pop && wr_en) begin
                    head_d = wr_data;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else if (wr_en) begin
                    tail_d = wr_data;
                    cnt_d  = 2'd2;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    if (wr_en) tail_d = wr_data;
                    else cnt_d = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rd_valid = (cnt_q != 2'd0);
    assign rd_data  = head_q;
    assign count    = cnt_q;

endmodule

// File: rtl/msgpass_buff_rd_ctrl.sv
// Read-side buffer controller: credit-gated address issue into a 2-entry
// output FIFO. Protocol checking is enabled by MSGPASS_RD_PROTOCOL_CHK_EN.
module msgpass_buff_rd_ctrl
    import msgPass_config_pkg::*;
#(
    parameter int ADDR_W = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int DATA_W = MSGPASS_BUFF_RDATA_WIDTH,
    parameter int SEL_W  = INCREMENT_SRC_SEL_WIDTH
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   layer_len,
    input  logic [SEL_W-1:0]  step_sel,
    input  logic [ADDR_W-1:0] stride,
    input  logic              wr_commit,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  credit_q, credit_d;
    logic              infl_q, infl_d;
    logic              infl_last_q, infl_last_d;

    logic              start_ok;
    logic              rd_en_c;
    logic              pop;
    logic [1:0]        occ;
    logic              fifo_valid;
    logic [DATA_W:0]   fifo_word;
    logic [1:0]        fifo_count;

    function automatic logic [ADDR_W-1:0] step_amt(
        input logic [SEL_W-1:0]  sel,
        input logic [ADDR_W-1:0] strd
    );
        unique case (step_sel_t'(sel))
            STEP_STRIDE: step_amt = strd;
            STEP_HOLD:   step_amt = '0;
            default:     step_amt = ADDR_W'(1);
        endcase
    endfunction

    assign start_ok = layer_start && (state_q == RD_IDLE);
    assign pop      = fifo_valid && out_ready;

    // Occupancy after this cycle's pop lets a read issue every cycle.
    assign occ = fifo_count + 2'(infl_q) - 2'(pop);

    assign rd_en_c = (state_q == RD_RUN) && (rem_q != '0)
                  && (credit_q != '0)
                  && (occ < 2'(MSGPASS_RD_FIFO_DEPTH));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            step_q      <= '0;
            rem_q       <= '0;
            credit_q    <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            step_q      <= step_d;
            rem_q       <= rem_d;
            credit_q    <= credit_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE: begin
                if (layer_start)
                    state_d = (layer_len == '0) ? RD_DONE : RD_RUN;
            end
            RD_RUN:   if (rem_q == '0) state_d = RD_DRAIN;
            RD_DRAIN: if (pop && fifo_word[DATA_W]) state_d = RD_DONE;
            RD_DONE:  state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        step_d = step_q;
        rem_d  = rem_q;
        if (start_ok) begin
            addr_d = base_addr;
            rem_d  = layer_len;
            step_d = step_amt(step_sel, stride);
        end else if (rd_en_c) begin
            addr_d = addr_q + step_q;
            rem_d  = rem_q - CNT_W'(1);
        end
        credit_d = credit_q;
        if (wr_commit && !rd_en_c && (credit_q != DEPTH_C))
            credit_d = credit_q + CNT_W'(1);
        else if (rd_en_c && !wr_commit)
            credit_d = credit_q - CNT_W'(1);
        infl_d      = rd_en_c;
        infl_last_d = rd_en_c && (rem_q == CNT_W'(1));
    end

    always_comb begin
        rd_en     = rd_en_c;
        rd_addr   = addr_q;
        busy      = (state_q == RD_RUN) || (state_q == RD_DRAIN);
        done      = (state_q == RD_DONE);
        out_valid = fifo_valid;
        out_last  = fifo_word[DATA_W];
        out_data  = fifo_word[DATA_W-1:0];
    end

    msgpass_rd_skid_fifo #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk      (sys_clk),
        .rst      (rst),
        .wr_en    (infl_q),
        .wr_data  ({infl_last_q, rd_data}),
        .rd_ready (out_ready),
        .rd_valid (fifo_valid),
        .rd_data  (fifo_word),
        .count    (fifo_count)
    );

`ifdef MSGPASS_RD_PROTOCOL_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
             || (layer_start && busy)
             || (wr_commit && (credit_q == DEPTH_C))
             || (layer_start && (layer_len > DEPTH_C));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_msgpass_buff_rd_ctrl.sv
// Bench for msgpass_buff_rd_ctrl: queue-based stream model plus directed
// checks on addressing, credit gating, back-pressure and reset.
module tb_msgpass_buff_rd_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 10;
    localparam int DEPTH = 128;
`ifdef MSGPASS_RD_PROTOCOL_CHK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          layer_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   layer_len = '0;
    logic [1:0]    step_sel = '0;
    logic [AW-1:0] stride = '0;
    logic          wr_commit = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;

    always #5 sys_clk = ~sys_clk;

    msgpass_buff_rd_ctrl dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .layer_start (layer_start),
        .base_addr   (base_addr),
        .layer_len   (layer_len),
        .step_sel    (step_sel),
        .stride      (stride),
        .wr_commit   (wr_commit),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    function automatic logic [DW-1:0] memval(input int a);
        return DW'(a * 13 + 300);
    endfunction

    // Synchronous buffer: data for rd_addr appears the cycle after rd_en.
    always @(posedge sys_clk) begin
        if (rd_en) rd_data <= memval(int'(rd_addr));
        else       rd_data <= DW'($urandom);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_err = 0;
    int          m_credit = 0;
    int          m_left = 0;
    int          m_addr = 0;
    int          m_step = 0;
    logic [10:0] exp_q[$];
    bit          p_stall = 0;
    logic [10:0] p_word = '0;
    int          rd_cyc[$];
    int          rd_adr[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    int          com_cyc[$];

    always @(negedge sys_clk) begin : mon
        int          sz;
        bit          pop;
        bit          nb;
        bit          nd;
        bit          ne;
        logic [10:0] w;
        if (m_valid) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("err", err, m_err);
            sz  = exp_q.size();
            pop = out_valid && out_ready;
            nb  = m_busy;
            nd  = 1'b0;
            ne  = m_err;
            if (p_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", {out_last, out_data}, p_word);
            end
            if (out_valid) begin
                chk("word_pending", int'(sz > 0), 1);
                if (sz > 0) chk("out_word", {out_last, out_data}, exp_q[0]);
            end
            if (pop && sz > 0) begin
                w = exp_q.pop_front();
                acc_cyc.push_back(cyc_n);
                if (w[10]) begin
                    nb = 1'b0;
                    nd = 1'b1;
                end
            end
            if (rd_en) begin
                chk("issue_allowed",
                    int'(m_busy && m_left > 0 && m_credit > 0), 1);
                chk("rd_addr", rd_addr, m_addr);
                rd_cyc.push_back(cyc_n);
                rd_adr.push_back(int'(rd_addr));
                exp_q.push_back({m_left == 1, memval(m_addr)});
                m_addr = (m_addr + m_step) % DEPTH;
                if (m_left > 0) m_left--;
            end
            chk("outstanding_le2", int'(exp_q.size() <= 2), 1);
            if (wr_commit) com_cyc.push_back(cyc_n);
            if (CHK_EN != 0 && wr_commit && m_credit == DEPTH) ne = 1'b1;
            if (wr_commit && !rd_en && m_credit < DEPTH) m_credit++;
            else if (rd_en && !wr_commit) m_credit--;
            if (layer_start) begin
                if (CHK_EN != 0 && (m_busy || layer_len > DEPTH)) ne = 1'b1;
                if (!m_busy && !m_done) begin
                    m_addr = int'(base_addr);
                    m_left = int'(layer_len);
                    case (step_sel)
                        2'd1:    m_step = int'(stride);
                        2'd2:    m_step = 0;
                        default: m_step = 1;
                    endcase
                    if (layer_len == 0) nd = 1'b1;
                    else nb = 1'b1;
                end
            end
            if (done) done_cyc.push_back(cyc_n);
            p_stall = out_valid && !out_ready;
            p_word  = {out_last, out_data};
            m_busy  = nb;
            m_done  = nd;
            m_err   = ne;
        end
        if (rst) begin
            m_valid  = 1'b1;
            m_busy   = 1'b0;
            m_done   = 1'b0;
            m_err    = 1'b0;
            m_credit = 0;
            m_left   = 0;
            p_stall  = 1'b0;
            exp_q.delete();
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic commit(input int n);
        repeat (n) begin
            wr_commit = 1'b1;
            tick();
        end
        wr_commit = 1'b0;
    endtask

    task automatic start(input int b, input int l, input int s, input int st);
        base_addr   = AW'(b);
        layer_len   = (AW + 1)'(l);
        step_sel    = 2'(s);
        stride      = AW'(st);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
    endtask

    task automatic clr();
        rd_cyc.delete();
        rd_adr.delete();
        acc_cyc.delete();
        done_cyc.delete();
        com_cyc.delete();
    endtask

    task automatic wait_done(input string nm, input int lim);
        int n0;
        int k;
        n0 = done_cyc.size();
        k  = 0;
        while (done_cyc.size() == n0 && k < lim) begin
            tick();
            k++;
        end
        chk({nm, "_done_seen"}, int'(done_cyc.size() > n0), 1);
    endtask

    task automatic chk_addrs(input string nm, input int exp[$]);
        chk({nm, "_n_reads"}, rd_adr.size(), exp.size());
        foreach (exp[i]) begin
            if (i < rd_adr.size())
                chk($sformatf("%s_addr%0d", nm, i), rd_adr[i], exp[i]);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int sc;
        int n;
        tick(3);
        @(negedge sys_clk);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        tick();
        rst = 1'b0;
        tick();

        // T1: preloaded credit, back-to-back issue
        out_ready = 1'b1;
        commit(8);
        clr();
        start(5, 4, 0, 0);
        wait_done("t1", 30);
        chk_addrs("t1", '{5, 6, 7, 8});
        chk("t1_accepted", acc_cyc.size(), 4);
        if (rd_cyc.size() == 4 && acc_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("t1_consec%0d", i), rd_cyc[i] - rd_cyc[0], i);
            chk("t1_valid_latency", acc_cyc[0] - rd_cyc[0], 2);
            chk("t1_done_after_last", done_cyc[0] - acc_cyc[3], 1);
        end
        // 4 credits must remain
        clr();
        start(20, 8, 0, 0);
        tick(12);
        chk("t1_credit_left", rd_cyc.size(), 4);
        commit(4);
        wait_done("t1b", 30);
        chk_addrs("t1b", '{20, 21, 22, 23, 24, 25, 26, 27});

        // T2: stride, wrap, hold, reserved select
        commit(4);
        clr();
        start(126, 4, 1, 1);
        wait_done("t2a", 30);
        chk_addrs("t2a", '{126, 127, 0, 1});
        commit(3);
        clr();
        start(0, 3, 1, 3);
        wait_done("t2b", 30);
        chk_addrs("t2b", '{0, 3, 6});
        commit(3);
        clr();
        start(9, 3, 2, 0);
        wait_done("t2c", 30);
        chk_addrs("t2c", '{9, 9, 9});
        commit(2);
        clr();
        start(127, 2, 3, 5);
        wait_done("t2d", 30);
        chk_addrs("t2d", '{127, 0});
        clr();
        sc = cyc_n;
        start(10, 0, 0, 0);
        wait_done("len0", 10);
        if (done_cyc.size() > 0)
            chk("len0_done_lat", done_cyc[0] - sc, 1);
        chk("len0_no_reads", rd_cyc.size(), 0);

        // T3: credit trickle
        clr();
        start(40, 4, 0, 0);
        for (int i = 0; i < 12; i++) begin
            wr_commit = (i % 3 == 0);
            tick();
        end
        wr_commit = 1'b0;
        wait_done("t3", 30);
        chk("t3_reads", rd_cyc.size(), 4);
        chk("t3_commits", com_cyc.size(), 4);
        if (rd_cyc.size() == 4 && com_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("t3_gap%0d", k), rd_cyc[k] - com_cyc[k], 1);
        end
        // commit coinciding with a read keeps the credit
        clr();
        start(50, 3, 0, 0);
        for (int i = 0; i < 8; i++) begin
            wr_commit = (i == 0 || i == 1 || i == 4);
            tick();
        end
        wr_commit = 1'b0;
        wait_done("t3b", 30);
        chk("t3b_reads", rd_cyc.size(), 3);
        if (rd_cyc.size() == 3 && com_cyc.size() == 3) begin
            chk("t3b_rd0", rd_cyc[0] - com_cyc[0], 1);
            chk("t3b_rd1", rd_cyc[1] - com_cyc[0], 2);
            chk("t3b_rd2", rd_cyc[2] - com_cyc[2], 1);
        end
        chk_addrs("t3b", '{50, 51, 52});

        // T4: back-pressure
        commit(6);
        clr();
        start(60, 6, 0, 0);
        tick();
        out_ready = 1'b0;
        tick(5);
        sc = cyc_n;
        out_ready = 1'b1;
        n = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] < sc) n++;
        chk("t4_stalled_reads", n, 2);
        wait_done("t4", 40);
        chk_addrs("t4", '{60, 61, 62, 63, 64, 65});
        chk("t4_accepted", acc_cyc.size(), 6);

        // T5: reset mid-layer
        commit(10);
        clr();
        start(70, 8, 0, 0);
        tick(3);
        rst = 1'b1;
        tick();
        @(negedge sys_clk);
        chk("t5_rd_en", rd_en, 0);
        chk("t5_rd_addr", rd_addr, 0);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_out_last", out_last, 0);
        chk("t5_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        clr();
        start(3, 2, 0, 0);
        tick(6);
        chk("t5_credit_zero", rd_cyc.size(), 0);
        commit(2);
        wait_done("t5", 30);
        chk_addrs("t5", '{3, 4});

        // T6: protocol violations
        clr();
        start(0, 2, 0, 0);
        tick();
        start(100, 5, 0, 0);
        commit(2);
        wait_done("t6a", 30);
        chk_addrs("t6a", '{0, 1});
        chk("t6_err_busy_start", err, CHK_EN);
        commit(130);
        chk("t6_err_overflow", err, CHK_EN);
        clr();
        start(0, 128, 0, 0);
        wait_done("t6_full", 300);
        chk("t6_full_reads", rd_cyc.size(), 128);
        clr();
        start(5, 3, 0, 0);
        tick(10);
        chk("t6_saturated", rd_cyc.size(), 0);
        chk("t6_err_sticky", err, CHK_EN);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
